// File: rtl/equation_arbiter.sv
// Round-robin front end that time-shares one external equation datapath
// between NUM_REQ requesters and returns tagged results on one response channel.
module equation_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned XW      = 2,
  parameter int unsigned YW      = 4,
  parameter int unsigned ZW      = 5,
  parameter int unsigned IDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*XW-1:0] req_x,
  input  logic [NUM_REQ*YW-1:0] req_y,
  output logic [XW-1:0]         eq_x,
  output logic [YW-1:0]         eq_y,
  input  logic [ZW-1:0]         eq_z,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [ZW-1:0]         rsp_z,
  output logic                  busy,
  output logic [15:0]           done_cnt
);

  localparam int unsigned CNTW = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] gnt_id;
  logic           gnt_found;
  logic [XW-1:0]  op_x;
  logic [YW-1:0]  op_y;
  logic [XW-1:0]  x_a [NUM_REQ];
  logic [YW-1:0]  y_a [NUM_REQ];

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
    assign x_a[g] = req_x[g*XW +: XW];
    assign y_a[g] = req_y[g*YW +: YW];
  end

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = IDW'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (gnt_found) begin
          req_ready = rst_n ? (NUM_REQ'(1) << gnt_id) : '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, result capture, rotation pointer and completion count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      op_x     <= '0;
      op_y     <= '0;
      rsp_z    <= '0;
      rsp_id   <= '0;
      done_cnt <= '0;
    end else begin
      if (state == IDLE && gnt_found) begin
        op_x   <= x_a[gnt_id];
        op_y   <= y_a[gnt_id];
        rsp_id <= gnt_id;
      end
      if (state == ISSUE) rsp_z <= eq_z;
      if (state == RESP && rsp_ready) begin
        done_cnt <= done_cnt + CNTW'(1);
        rr_ptr   <= (rsp_id == IDW'(NUM_REQ - 1)) ? '0 : rsp_id + IDW'(1);
      end
    end
  end

  assign eq_x      = op_x;
  assign eq_y      = op_y;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: doc/equation_arbiter.md
Name: equation_arbiter

Overview:
- Shares one combinational equation datapath (operands x[1:0] and y[3:0], result z[4:0]) between NUM_REQ requesters.
- Round-robin arbitration; the operands of the winning request are latched and driven onto the shared datapath.
- The result is captured in a register and returned on a single valid/ready response channel, tagged with the requester id.
- Sits between the requesting blocks and the single Equation instance; the datapath itself stays outside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- XW, 2, width of the x operand.
- YW, 4, width of the y operand.
- ZW, 5, width of the z result.
- IDW, 2, width of the requester id; must satisfy 2**IDW >= NUM_REQ.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_x  in  NUM_REQ*XW  packed x operands; requester i uses bits [i*XW +: XW].
- req_y  in  NUM_REQ*YW  packed y operands; requester i uses bits [i*YW +: YW].
- eq_x  out  XW  x operand to the shared datapath.
- eq_y  out  YW  y operand to the shared datapath.
- eq_z  in  ZW  result from the shared datapath (combinational from eq_x/eq_y).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester whose result is presented.
- rsp_z  out  ZW  registered result.
- busy  out  1  high whenever state != IDLE.
- done_cnt  out  16  count of completed responses; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE, rr_ptr=0, op_x=0, op_y=0, rsp_z=0, rsp_id=0, done_cnt=0.
  - All outputs read 0: req_ready=0, rsp_valid=0, busy=0, eq_x=0, eq_y=0.
  - A reset mid-transaction discards that transaction; no response is produced for it.
- eq_x/eq_y always equal the internal op_x/op_y registers, so the datapath input is stable and glitch-free.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching from rr_ptr upward and wrapping at NUM_REQ-1.
  - req_ready[g]=1 combinationally for the granted index g only.
  - On that edge: op_x <= req_x[g], op_y <= req_y[g], rsp_id <= g, then go to ISSUE.
  - No valid request: stay in IDLE, req_ready=0.
- ISSUE (one cycle): rsp_z <= eq_z, then go to RESP. req_ready=0.
- RESP:
  - rsp_valid=1, with rsp_z and rsp_id held stable.
  - On rsp_valid && rsp_ready: done_cnt increments, rr_ptr <= (rsp_id+1) mod NUM_REQ, then go to IDLE.
  - Otherwise stay in RESP; back-pressure is unlimited.
  - req_ready=0 throughout.
- Latency: accept at edge T, rsp_valid high in the cycle after edge T+1.
  - Minimum spacing between accepts is 3 cycles when rsp_ready is held high.
- Request rules:
  - A requester holds req_valid and its operands stable until it sees req_ready.
  - req_valid must not depend combinationally on req_ready.
  - A requester that deasserts before being granted is simply skipped.
- Fairness: the last served requester gets the lowest priority. With all requesters active, grants follow a strict rotation (0,1,2,3,0,...).
- Width rules:
  - eq_z is captured unmodified (ZW bits); the block performs no arithmetic on it.
  - Operand slices are taken exactly as packed; there is no sign handling.
- Simultaneous events: a new req_valid arriving while in RESP is not accepted until the FSM has returned to IDLE.
- done_cnt wraps silently; no overflow flag.

Test Plan:
- Single request, bench datapath model eq_z = eq_x + eq_y:
  - Stimulus: requester 2 sends x=3, y=15, rsp_ready held 1.
  - Required: req_ready[2] for 1 cycle; rsp_valid 2 cycles later with rsp_z=18, rsp_id=2; done_cnt=1.
- All four requesters valid continuously, x=i, y=i:
  - Required: grant order 0,1,2,3,0.
  - rsp_z values 0,2,4,6,0; responses spaced 3 cycles apart.
- Back-pressure:
  - Stimulus: requester 1 sends x=0, y=0; rsp_ready=0 for 5 cycles, then 1.
  - Required: rsp_valid held for 6 cycles with rsp_z=0, rsp_id=1 stable; req_ready stays 0 while requester 3 is waiting.
  - Requester 3 is granted only after the handshake.
- Reset mid-operation:
  - Stimulus: accept requester 0, then rst_n=0 during ISSUE.
  - Required: next cycle rsp_valid=0, busy=0, done_cnt=0, eq_x=0, eq_y=0; no response is ever issued for requester 0.
- Priority rotation after idle:
  - Stimulus: serve requester 3, idle 4 cycles, then requesters 0 and 3 raise valid together.
  - Required: requester 0 is granted first (rr_ptr wrapped to 0), then requester 3.
- Counter wrap:
  - Stimulus: force-drive 65536 responses (or preload via reset-free long run).
  - Required: done_cnt reads 0 after the 65536th handshake.
